dps_frame_ctrl: RTL and testbench

Parametrised frame controller for the digital pixel sensor array: sequences erase, exposure, ADC ramp conversion and row-by-row readout of the pixel memories onto the shared data bus. It supports a runtime-programmable exposure time, any number of readout rows, and single-shot or continuous capture. The block sits between the system-level start/config logic and the pixel array, and hands each row word to a downstream consumer with a valid/ready handshake.

---
 rtl/dps_frame_ctrl_if.sv | 23 ++
 rtl/dps_frame_ctrl.sv | 158 +++++++++++++++
 tb/tb_dps_frame_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/dps_frame_ctrl_if.sv
// Pixel-array strobe bus and row readout handshake between the frame controller and the array/consumer.
interface dps_frame_ctrl_if #(
    parameter int unsigned ROWS     = 2,
    parameter int unsigned ADC_BITS = 8
);
    logic                erase;
    logic                expose;
    logic                convert;
    logic [ADC_BITS-1:0] adc_count;
    logic [ROWS-1:0]     read_en;
    logic                data_valid;
    logic                data_ready;

    modport master (
        output erase, expose, convert, adc_count, read_en, data_valid,
        input  data_ready
    );

    modport slave (
        input  erase, expose, convert, adc_count, read_en, data_valid,
        output data_ready
    );
endinterface

// File: rtl/dps_frame_ctrl.sv
// Frame sequencer for the digital pixel sensor: erase, exposure, ramp conversion and
// row-by-row readout with valid/ready backpressure, single-shot or continuous.
module dps_frame_ctrl #(
    parameter int unsigned ROWS     = 2,
    parameter int unsigned ADC_BITS = 8,
    parameter int unsigned EXP_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             continuous,
    input  logic [EXP_W-1:0] expose_time,
    dps_frame_ctrl_if.master pix,
    output logic             busy,
    output logic             frame_done,
    output logic             overrun
);
    localparam int unsigned RW = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ERASE   = 3'd1;
    localparam logic [2:0] S_EXPOSE  = 3'd2;
    localparam logic [2:0] S_CONVERT = 3'd3;
    localparam logic [2:0] S_READ    = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [ADC_BITS-1:0] ADC_LAST = '1;
    localparam logic [RW-1:0]       ROW_LAST = RW'(ROWS - 1);

    logic [2:0]          state,      state_nxt;
    logic [EXP_W-1:0]    exp_m1,     exp_m1_nxt;
    logic [EXP_W-1:0]    exp_cnt,    exp_cnt_nxt;
    logic [RW-1:0]       row,        row_nxt;
    logic [ADC_BITS-1:0] adc_q,      adc_nxt;
    logic                overrun_q,  overrun_nxt;
    logic                erase_q,    erase_nxt;
    logic                expose_q,   expose_nxt;
    logic                convert_q,  convert_nxt;
    logic                valid_q,    valid_nxt;
    logic                busy_q,     busy_nxt;
    logic                done_q,     done_nxt;
    logic [ROWS-1:0]     read_en_q,  read_en_nxt;
    logic [EXP_W-1:0]    lat_val;

    // Exposure length minus one, with a requested length of 0 behaving as 1
    assign lat_val = (expose_time == '0) ? '0 : expose_time - EXP_W'(1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            exp_m1    <= '0;
            exp_cnt   <= '0;
            row       <= '0;
            adc_q     <= '0;
            overrun_q <= 1'b0;
            erase_q   <= 1'b0;
            expose_q  <= 1'b0;
            convert_q <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            read_en_q <= '0;
        end else begin
            state     <= state_nxt;
            exp_m1    <= exp_m1_nxt;
            exp_cnt   <= exp_cnt_nxt;
            row       <= row_nxt;
            adc_q     <= adc_nxt;
            overrun_q <= overrun_nxt;
            erase_q   <= erase_nxt;
            expose_q  <= expose_nxt;
            convert_q <= convert_nxt;
            valid_q   <= valid_nxt;
            busy_q    <= busy_nxt;
            done_q    <= done_nxt;
            read_en_q <= read_en_nxt;
        end
    end

    // Next state, counters, and outputs decoded from the next state so they register with it
    always_comb begin
        state_nxt   = state;
        exp_m1_nxt  = exp_m1;
        exp_cnt_nxt = exp_cnt;
        row_nxt     = row;
        adc_nxt     = '0;
        overrun_nxt = overrun_q;

        case (state)
            S_IDLE: begin
                if (start) begin
                    exp_m1_nxt  = lat_val;
                    overrun_nxt = 1'b0;
                    state_nxt   = S_ERASE;
                end
            end
            S_ERASE: begin
                exp_cnt_nxt = exp_m1;
                state_nxt   = S_EXPOSE;
            end
            S_EXPOSE: begin
                if (exp_cnt == '0) begin
                    state_nxt = S_CONVERT;
                end else begin
                    exp_cnt_nxt = exp_cnt - EXP_W'(1);
                end
            end
            S_CONVERT: begin
                if (adc_q == ADC_LAST) begin
                    row_nxt   = '0;
                    state_nxt = S_READ;
                end else begin
                    adc_nxt = adc_q + ADC_BITS'(1);
                end
            end
            S_READ: begin
                if (valid_q && pix.data_ready) begin
                    if (row == ROW_LAST) begin
                        state_nxt = S_DONE;
                    end else begin
                        row_nxt = row + RW'(1);
                    end
                end
            end
            S_DONE: begin
                if (continuous) begin
                    exp_m1_nxt = lat_val;
                    state_nxt  = S_ERASE;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        if (start && (state != S_IDLE)) begin
            overrun_nxt = 1'b1;
        end

        erase_nxt   = (state_nxt == S_ERASE);
        expose_nxt  = (state_nxt == S_EXPOSE);
        convert_nxt = (state_nxt == S_CONVERT);
        valid_nxt   = (state_nxt == S_READ);
        busy_nxt    = (state_nxt != S_IDLE);
        done_nxt    = (state_nxt == S_DONE);
        read_en_nxt = (state_nxt == S_READ) ? (ROWS'(1) << row_nxt) : '0;
    end

    assign pix.erase      = erase_q;
    assign pix.expose     = expose_q;
    assign pix.convert    = convert_q;
    assign pix.adc_count  = adc_q;
    assign pix.read_en    = read_en_q;
    assign pix.data_valid = valid_q;
    assign busy           = busy_q;
    assign frame_done     = done_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_dps_frame_ctrl.sv
// Scoreboard bench for dps_frame_ctrl: expected pulse lengths, row words and frame_done
// cycles are queued when a frame is launched and retired by a negedge monitor.
module tb_dps_frame_ctrl;
    localparam int ROWS     = 2;
    localparam int ADC_BITS = 8;
    localparam int EXP_W    = 8;
    localparam int CONV     = 1 << ADC_BITS;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             continuous;
    logic [EXP_W-1:0] expose_time;
    logic             busy;
    logic             frame_done;
    logic             overrun;

    dps_frame_ctrl_if #(.ROWS(ROWS), .ADC_BITS(ADC_BITS)) pix ();

    dps_frame_ctrl #(.ROWS(ROWS), .ADC_BITS(ADC_BITS), .EXP_W(EXP_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .expose_time(expose_time),
        .pix        (pix),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    int              exp_len_q[$];
    int              exp_done_q[$];
    logic [ROWS-1:0] exp_row_q[$];

    int erase_run = 0, exp_run = 0, adc_model = 0;
    int adc_err = 0, excl_err = 0, rd_err = 0, hold_err = 0;
    int stall_cnt = 0, done_seen = 0;

    // Monitor: retire scoreboard entries as the DUT produces them
    always @(negedge clk) begin
        if (!reset) begin
            erase_run = 0;
            exp_run   = 0;
            adc_model = 0;
        end else begin
            if (int'(pix.erase) + int'(pix.expose) + int'(pix.convert) + int'(pix.data_valid) > 1)
                excl_err++;
            if (pix.erase) erase_run++;
            else if (erase_run != 0) begin
                check("erase_len", erase_run, 1);
                erase_run = 0;
            end
            if (pix.expose) exp_run++;
            else if (exp_run != 0) begin
                if (exp_len_q.size() == 0) check("expose_unexpected", exp_run, 0);
                else check("expose_len", exp_run, exp_len_q.pop_front());
                exp_run = 0;
            end
            if (pix.convert) begin
                if (pix.adc_count != ADC_BITS'(adc_model)) adc_err++;
                adc_model++;
            end else begin
                if (adc_model != 0) begin
                    check("convert_len", adc_model, CONV);
                    adc_model = 0;
                end
                if (pix.adc_count != '0) adc_err++;
            end
            if (pix.data_valid) begin
                if (pix.data_ready) begin
                    if (exp_row_q.size() == 0) check("row_unexpected", pix.read_en, 0);
                    else check("row_word", pix.read_en, exp_row_q.pop_front());
                end else begin
                    stall_cnt++;
                    if (pix.read_en != 2'b01) hold_err++;
                end
            end else if (pix.read_en != '0) rd_err++;
            if (frame_done) begin
                done_seen++;
                if (exp_done_q.size() == 0) check("done_unexpected", cyc, 0);
                else check("done_cycle", cyc, exp_done_q.pop_front());
            end
        end
    end

    // Launch one frame and queue what it must produce
    task automatic start_frame(input int n, input int stall);
        int ne;
        ne = (n == 0) ? 1 : n;
        @(posedge clk); #1;
        expose_time = EXP_W'(n);
        start = 1'b1;
        exp_len_q.push_back(ne);
        exp_done_q.push_back(cyc + ne + CONV + ROWS + 2 + stall);
        for (int r = 0; r < ROWS; r++) exp_row_q.push_back(ROWS'(1) << r);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_done_q.size() == 0 && !busy) break;
        end
        check("idle_reached", (exp_done_q.size() == 0 && !busy), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d1, ds;
        reset = 1'b0; start = 1'b0; continuous = 1'b0; expose_time = '0;
        pix.data_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_strobes", {pix.erase, pix.expose, pix.convert, pix.data_valid, frame_done, overrun}, 0);
        check("rst_adc", pix.adc_count, 0);
        check("rst_read_en", pix.read_en, 0);
        reset = 1'b1;

        // single shot, longest exposure
        start_frame(255, 0);
        check("first_erase", pix.erase, 1);
        wait_idle(2000);
        check("busy_after", busy, 0);

        // zero exposure behaves as one cycle; mid-frame expose_time change ignored
        start_frame(0, 0);
        wait_idle(1000);
        start_frame(3, 0);
        @(posedge clk); #1;
        expose_time = 8'd9;
        wait_idle(1000);

        // backpressure on row 0
        pix.data_ready = 1'b0;
        start_frame(10, 5);
        for (int i = 0; i < 1000 && !pix.data_valid; i++) @(negedge clk);
        check("valid_seen", pix.data_valid, 1);
        repeat (5) @(posedge clk);
        #1;
        pix.data_ready = 1'b1;
        wait_idle(1000);
        check("stall_cycles", stall_cnt, 5);
        check("stall_hold", hold_err, 0);

        // continuous, cleared during second conversion
        continuous = 1'b1;
        start_frame(4, 0);
        d1 = exp_done_q[exp_done_q.size() - 1];
        exp_len_q.push_back(4);
        exp_done_q.push_back(d1 + 264);
        for (int r = 0; r < ROWS; r++) exp_row_q.push_back(ROWS'(1) << r);
        ds = done_seen;
        for (int i = 0; i < 1000 && done_seen == ds; i++) @(negedge clk);
        check("cont_first_done", done_seen, ds + 1);
        for (int i = 0; i < 100 && !pix.convert; i++) @(negedge clk);
        check("cont_in_convert", pix.convert, 1);
        continuous = 1'b0;
        wait_idle(1000);
        repeat (5) @(negedge clk);
        check("cont_idle", busy, 0);
        check("cont_done_count", done_seen, ds + 2);

        // start during EXPOSE sets sticky overrun, timing untouched
        start_frame(20, 0);
        for (int i = 0; i < 10 && !pix.expose; i++) @(negedge clk);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("overrun_set", overrun, 1);
        wait_idle(1000);
        check("overrun_sticky", overrun, 1);
        start_frame(5, 0);
        check("overrun_clear", overrun, 0);
        wait_idle(1000);

        // asynchronous reset mid-conversion
        start_frame(2, 0);
        for (int i = 0; i < 600 && pix.adc_count != 8'd100; i++) @(negedge clk);
        check("adc_reached_100", pix.adc_count, 100);
        #2;
        reset = 1'b0;
        #1;
        check("arst_strobes", {pix.erase, pix.expose, pix.convert, pix.data_valid, frame_done, busy}, 0);
        check("arst_adc", pix.adc_count, 0);
        check("arst_read_en", pix.read_en, 0);
        exp_done_q.delete();
        exp_row_q.delete();
        exp_len_q.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        start_frame(2, 0);
        check("post_rst_erase", pix.erase, 1);
        wait_idle(1000);

        check("adc_sequence", adc_err, 0);
        check("strobe_exclusive", excl_err, 0);
        check("read_en_idle", rd_err, 0);
        check("rows_pending", exp_row_q.size(), 0);
        check("expose_pending", exp_len_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
